// File: rtl/ex_mem_pipe_reg.sv
// rtl/ex_mem_pipe_reg.sv - EX/MEM pipeline register with Z/N flags, OUT-port latch and forwarding tap
// Stall holds every register; flush inserts a bubble but leaves flags and the OUT latch alone.
module ex_mem_pipe_reg #(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  ex_valid,
   input  logic [DATA_W-1:0]     ex_out,
   input  logic [DATA_W-1:0]     ex_store_data,
   input  logic                  ex_zero,
   input  logic                  ex_negative,
   input  logic                  ex_flags_we,
   input  logic                  ex_reg_we,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  ex_mem_write,
   input  logic                  ex_outPort,
   input  logic [DATA_W-1:0]     ex_outPort_Data,
   output logic                  mem_valid,
   output logic [DATA_W-1:0]     mem_alu_result,
   output logic [DATA_W-1:0]     mem_store_data,
   output logic                  mem_reg_we,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  mem_mem_read,
   output logic                  mem_mem_write,
   output logic                  flag_z,
   output logic                  flag_n,
   output logic [DATA_W-1:0]     out_port_q,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_rd,
   output logic [DATA_W-1:0]     fwd_data
);

   logic                  r_valid;
   logic [DATA_W-1:0]     r_alu_result;
   logic [DATA_W-1:0]     r_store_data;
   logic                  r_reg_we;
   logic [REG_ADDR_W-1:0] r_rd;
   logic                  r_mem_read;
   logic                  r_mem_write;
   logic                  r_flag_z;
   logic                  r_flag_n;
   logic [DATA_W-1:0]     r_out_port;

   logic w_load;
   logic w_flags_upd;
   logic w_out_upd;

   assign w_load      = ~stall & ~flush;
   assign w_flags_upd = w_load & ex_valid & ex_flags_we;
   // OUT data may float when no OUT is in EX, so it is only sampled on a real OUT.
   assign w_out_upd   = w_load & ex_valid & ex_outPort;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid      <= 1'b0;
         r_alu_result <= '0;
         r_store_data <= '0;
         r_reg_we     <= 1'b0;
         r_rd         <= '0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
      end else if (!stall) begin
         if (flush) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_store_data <= '0;
            r_reg_we     <= 1'b0;
            r_rd         <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
         end else begin
            r_valid      <= ex_valid;
            r_alu_result <= ex_out;
            r_store_data <= ex_store_data;
            r_reg_we     <= ex_reg_we & ex_valid;
            r_rd         <= ex_rd;
            r_mem_read   <= ex_mem_read & ex_valid;
            r_mem_write  <= ex_mem_write & ex_valid;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_flag_z   <= 1'b0;
         r_flag_n   <= 1'b0;
         r_out_port <= '0;
      end else begin
         if (w_flags_upd) begin
            r_flag_z <= ex_zero;
            r_flag_n <= ex_negative;
         end
         if (w_out_upd) begin
            r_out_port <= ex_outPort_Data;
         end
      end
   end

   assign mem_valid      = r_valid;
   assign mem_alu_result = r_alu_result;
   assign mem_store_data = r_store_data;
   assign mem_reg_we     = r_reg_we;
   assign mem_rd         = r_rd;
   assign mem_mem_read   = r_mem_read;
   assign mem_mem_write  = r_mem_write;
   assign flag_z         = r_flag_z;
   assign flag_n         = r_flag_n;
   assign out_port_q     = r_out_port;

   // Loads are excluded: their data is not known until MEM completes.
   assign fwd_valid = r_reg_we & ~r_mem_read;
   assign fwd_rd    = r_rd;
   assign fwd_data  = r_alu_result;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb/tb_ex_mem_pipe_reg.sv - scoreboard bench for ex_mem_pipe_reg
module tb_ex_mem_pipe_reg;

   typedef struct packed {
      logic       stall, flush, v;
      logic [7:0] out, sd;
      logic       z, n, fwe, rwe;
      logic [1:0] rd;
      logic       mr, mw, op;
      logic [7:0] opd;
   } in_t;

   typedef struct packed {
      logic       v;
      logic [7:0] alu, st;
      logic       we;
      logic [1:0] rd;
      logic       mr, mw, fz, fn;
      logic [7:0] oq;
      logic       fwd;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       stall, flush, ex_valid, ex_zero, ex_negative, ex_flags_we, ex_reg_we;
   logic       ex_mem_read, ex_mem_write, ex_outPort;
   logic [7:0] ex_out, ex_store_data, ex_outPort_Data;
   logic [1:0] ex_rd;
   logic       mem_valid, mem_reg_we, mem_mem_read, mem_mem_write, flag_z, flag_n, fwd_valid;
   logic [7:0] mem_alu_result, mem_store_data, out_port_q, fwd_data;
   logic [1:0] mem_rd, fwd_rd;

   int   n_total = 0;
   int   n_pass  = 0;
   exp_t sb_q[$];

   ex_mem_pipe_reg #(.DATA_W(8), .REG_ADDR_W(2)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_out(ex_out), .ex_store_data(ex_store_data),
      .ex_zero(ex_zero), .ex_negative(ex_negative), .ex_flags_we(ex_flags_we),
      .ex_reg_we(ex_reg_we), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_outPort(ex_outPort), .ex_outPort_Data(ex_outPort_Data),
      .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
      .mem_reg_we(mem_reg_we), .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
      .mem_mem_write(mem_mem_write), .flag_z(flag_z), .flag_n(flag_n),
      .out_port_q(out_port_q), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
      n_total++;
      if (act !== exp_v) $display("FAIL %s: got %h expected %h", nm, act, exp_v);
      else n_pass++;
   endtask

   task automatic check_all(input string tag, input exp_t e);
      chk({tag, ".mem_valid"},      {7'b0, mem_valid},     {7'b0, e.v});
      chk({tag, ".mem_alu_result"}, mem_alu_result,        e.alu);
      chk({tag, ".mem_store_data"}, mem_store_data,        e.st);
      chk({tag, ".mem_reg_we"},     {7'b0, mem_reg_we},    {7'b0, e.we});
      chk({tag, ".mem_rd"},         {6'b0, mem_rd},        {6'b0, e.rd});
      chk({tag, ".mem_mem_read"},   {7'b0, mem_mem_read},  {7'b0, e.mr});
      chk({tag, ".mem_mem_write"},  {7'b0, mem_mem_write}, {7'b0, e.mw});
      chk({tag, ".flag_z"},         {7'b0, flag_z},        {7'b0, e.fz});
      chk({tag, ".flag_n"},         {7'b0, flag_n},        {7'b0, e.fn});
      chk({tag, ".out_port_q"},     out_port_q,            e.oq);
      chk({tag, ".fwd_valid"},      {7'b0, fwd_valid},     {7'b0, e.fwd});
      chk({tag, ".fwd_rd"},         {6'b0, fwd_rd},        {6'b0, e.rd});
      chk({tag, ".fwd_data"},       fwd_data,              e.alu);
      chk({tag, ".out_port_known"}, {7'b0, $isunknown(out_port_q)}, 8'h00);
   endtask

   // Monitor: every edge with a pending expectation is compared just after the edge.
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) check_all("sb", sb_q.pop_front());
   end

   task automatic drive(input in_t i);
      stall           = i.stall;
      flush           = i.flush;
      ex_valid        = i.v;
      ex_out          = i.out;
      ex_store_data   = i.sd;
      ex_zero         = i.z;
      ex_negative     = i.n;
      ex_flags_we     = i.fwe;
      ex_reg_we       = i.rwe;
      ex_rd           = i.rd;
      ex_mem_read     = i.mr;
      ex_mem_write    = i.mw;
      ex_outPort      = i.op;
      ex_outPort_Data = i.op ? i.opd : 8'hzz;
   endtask

   task automatic step(input in_t i, input exp_t e);
      @(negedge clk);
      drive(i);
      sb_q.push_back(e);
   endtask

   //            stall flush v   out    sd     z     n     fwe   rwe   rd    mr    mw    op    opd
   //            v     alu    st     we    rd    mr    mw    fz    fn    oq     fwd
   initial begin
      drive('{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00});
      #2;
      check_all("reset0", '{1'b0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
      @(negedge clk);
      reset = 1'b1;

      step('{1'b0, 1'b0, 1'b1, 8'h3C, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00},
           '{1'b1, 8'h3C, 8'h11, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1});
      for (int k = 0; k < 3; k++)
         step('{1'b1, 1'b0, 1'b1, 8'hFF, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 8'h77},
              '{1'b1, 8'h3C, 8'h11, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1});
      step('{1'b0, 1'b0, 1'b1, 8'hFF, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 8'h77},
           '{1'b1, 8'hFF, 8'h22, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 1'b1});
      step('{1'b0, 1'b1, 1'b1, 8'h55, 8'h66, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 8'h99},
           '{1'b0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 1'b0});
      step('{1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00},
           '{1'b1, 8'h12, 8'h34, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 1'b1});
      step('{1'b1, 1'b1, 1'b1, 8'h99, 8'h98, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'h44},
           '{1'b1, 8'h12, 8'h34, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 1'b1});
      step('{1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 8'hA5},
           '{1'b1, 8'h01, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0});
      for (int k = 0; k < 4; k++)
         step('{1'b0, 1'b0, 1'b1, 8'(k + 2), 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'(k), 1'b0, 1'b0, 1'b0, 8'h00},
              '{1'b1, 8'(k + 2), 8'h00, 1'b1, 2'(k), 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1});
      step('{1'b0, 1'b0, 1'b0, 8'h07, 8'h08, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 8'hC3},
           '{1'b0, 8'h07, 8'h08, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0});
      step('{1'b0, 1'b0, 1'b1, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00},
           '{1'b1, 8'h40, 8'h00, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0});
      step('{1'b0, 1'b0, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00},
           '{1'b0, 8'h40, 8'h00, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0});
      step('{1'b0, 1'b0, 1'b1, 8'h80, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00},
           '{1'b1, 8'h80, 8'hAB, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0});

      // Asynchronous reset mid-run while mem_valid=1, checked before any edge.
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_all("async_rst", '{1'b0, 8'h00, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
      @(negedge clk);
      reset = 1'b1;
      step('{1'b0, 1'b0, 1'b1, 8'h5A, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00},
           '{1'b1, 8'h5A, 8'h00, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1});

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 8'(sb_q.size()), 8'h00);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
